register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of every register and data port (legal range 4-64).
REQ-002 Parameter DEPTH, default 8, SHALL set the register count (power of two, 2-32); SEL_W = log2(DEPTH) is derived and not overridable.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 I  input  WIDTH  SHALL carry the write data for the load operation.
REQ-006 OutASel, OutBSel  input  SEL_W  SHALL select the register driven on OutA and OutB respectively.
REQ-007 FunSel  input  3  SHALL select the operation applied to enabled registers.
REQ-008 RegSel  input  DEPTH  SHALL be an active-low enable mask; bit k low enables register k; any number of bits may be low.
REQ-009 ClearAll  input  1  SHALL request a sequential clear of all registers.
REQ-010 OutA, OutB  output  WIDTH  SHALL be the combinational contents of the selected registers.
REQ-011 Busy  output  1  SHALL be high while a clear sweep is in progress.
REQ-012 Carry  output  1  SHALL be the registered wrap flag of the previous cycle's increment/decrement.

Function
REQ-013 FunSel encoding, per enabled register: 000 decrement, 001 increment, 010 load I, 011 clear, 100 shift left logical, 101 shift right logical, 110 rotate left by 1, 111 hold.
REQ-014 Increment and decrement SHALL wrap modulo 2^WIDTH: all-ones+1 -> 0; 0-1 -> all-ones.
REQ-015 Carry SHALL be set on an edge where at least one enabled register wraps under increment/decrement in IDLE, and SHALL clear on every other edge.
REQ-016 Registers whose RegSel bit is high SHALL hold their value.
REQ-017 OutA and OutB SHALL reflect register contents with zero latency; a write becomes visible after the writing edge, with no write-to-read bypass.
REQ-018 OutASel and OutBSel SHALL be independent; equal selects SHALL return the same value on both ports.
REQ-019 The FSM SHALL have two states: IDLE and SWEEP.
REQ-020 In IDLE with ClearAll=1 at an edge, the FSM SHALL suppress that edge's FunSel/RegSel write, go to SWEEP, and set the sweep index to 0.
REQ-021 In SWEEP, each edge SHALL clear register[index] and increment the index; the edge that clears index DEPTH-1 SHALL return the FSM to IDLE.
REQ-022 Busy SHALL be high in SWEEP only, for exactly DEPTH cycles per sweep.
REQ-023 In SWEEP, FunSel, RegSel, I and ClearAll SHALL be ignored; Carry SHALL read 0; reads SHALL remain valid.
REQ-024 ClearAll held high across the SWEEP-to-IDLE return SHALL start a new sweep on the first IDLE edge.

Reset
REQ-025 Reset low SHALL immediately, independent of Clock, clear all registers, set Carry=0, set Busy=0, set the FSM to IDLE and the index to 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep; after release, the block SHALL be in IDLE with all registers at 0.
REQ-027 On the first rising edge after Reset releases, the block SHALL operate normally.

Verification
REQ-028 Load 0x1234 with RegSel=0xFE (reg0 only), OutASel=0, OutBSel=1 -> OutA=0x1234, OutB=0x0000 after the edge.
REQ-029 Reg3=0xFFFF, FunSel=001, RegSel=0xF7 -> reg3=0x0000 and Carry=1 for one cycle; next edge with FunSel=111 -> Carry=0.
REQ-030 RegSel=0x00, FunSel=010, I=0x00A5 -> all 8 registers read 0x00A5; then FunSel=110 -> all registers read 0x014A.
REQ-031 All registers 0x5555, ClearAll pulsed one cycle with FunSel=010, I=0xAAAA, RegSel=0x00 -> no load occurs; Busy high for 8 cycles; reg k reads 0 from the (k+1)th edge after the request; Busy low afterwards.
REQ-032 Reset asserted at sweep index 3, off a clock edge -> outputs clear immediately; all registers 0; Busy=0; after release, load 0x0F0F to reg7 -> OutA=0x0F0F with OutASel=7.
REQ-033 WIDTH=8, DEPTH=4: decrement reg0 from 0x00 -> 0xFF with Carry=1; shift right 0x81 -> 0x40.

Source files
------------

// File: rtl/register_bank.sv
// Parameterised register bank with per-register enable mask, eight unary operations,
// two combinational read ports and a sequential one-register-per-cycle clear sweep.
module register_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] OutASel,
  input  logic [SEL_W-1:0] OutBSel,
  input  logic [2:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic             ClearAll,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Busy,
  output logic             Carry
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (ClearAll) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A ClearAll request edge in IDLE drops that edge's register operation.
  always_comb begin
    carry_d = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k] = regs_q[k];
    end
    if (state_q == StSweep) begin
      regs_d[idx_q] = '0;
    end else if (!ClearAll) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!RegSel[k]) begin
          case (FunSel)
            3'b000: begin
              regs_d[k] = regs_q[k] - 1'b1;
              if (regs_q[k] == '0) carry_d = 1'b1;
            end
            3'b001: begin
              regs_d[k] = regs_q[k] + 1'b1;
              if (regs_q[k] == '1) carry_d = 1'b1;
            end
            3'b010: regs_d[k] = I;
            3'b011: regs_d[k] = '0;
            3'b100: regs_d[k] = {regs_q[k][WIDTH-2:0], 1'b0};
            3'b101: regs_d[k] = {1'b0, regs_q[k][WIDTH-1:1]};
            3'b110: regs_d[k] = {regs_q[k][WIDTH-2:0], regs_q[k][WIDTH-1]};
            default: regs_d[k] = regs_q[k];
          endcase
        end
      end
    end
  end

  always_comb begin
    OutA  = regs_q[OutASel];
    OutB  = regs_q[OutBSel];
    Busy  = (state_q == StSweep);
    Carry = carry_q;
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: default 16x8 instance plus an 8x4 instance.
module tb_register_bank;

  logic        clk;
  logic        rst_n;

  logic [15:0] i16;
  logic [2:0]  a_sel, b_sel, fun;
  logic [7:0]  reg_sel;
  logic        clr;
  logic [15:0] out_a, out_b;
  logic        busy, carry;

  logic [7:0]  i8;
  logic [1:0]  a_sel8, b_sel8;
  logic [2:0]  fun8;
  logic [3:0]  reg_sel8;
  logic        clr8;
  logic [7:0]  out_a8, out_b8;
  logic        busy8, carry8;

  int n_checks = 0;
  int n_err    = 0;

  register_bank u_dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .I       (i16),
    .OutASel (a_sel),
    .OutBSel (b_sel),
    .FunSel  (fun),
    .RegSel  (reg_sel),
    .ClearAll(clr),
    .OutA    (out_a),
    .OutB    (out_b),
    .Busy    (busy),
    .Carry   (carry)
  );

  register_bank #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .Clock   (clk),
    .Reset   (rst_n),
    .I       (i8),
    .OutASel (a_sel8),
    .OutBSel (b_sel8),
    .FunSel  (fun8),
    .RegSel  (reg_sel8),
    .ClearAll(clr8),
    .OutA    (out_a8),
    .OutB    (out_b8),
    .Busy    (busy8),
    .Carry   (carry8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [2:0] sel, input logic [15:0] exp, input string tag);
    a_sel = sel;
    #1;
    check(tag, 64'(out_a), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    i16 = '0; a_sel = '0; b_sel = '0; fun = 3'b111; reg_sel = 8'hFF; clr = 1'b0;
    i8 = '0; a_sel8 = '0; b_sel8 = '0; fun8 = 3'b111; reg_sel8 = 4'hF; clr8 = 1'b0;
    #13;
    check("reset_outa", 64'(out_a), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_carry", 64'(carry), 64'h0);
    rst_n = 1'b1;
    tick();

    // Load reg0 only; no bypass before the edge
    i16 = 16'h1234; fun = 3'b010; reg_sel = 8'hFE; a_sel = 3'd0; b_sel = 3'd1;
    #1;
    check("no_bypass", 64'(out_a), 64'h0);
    tick();
    check("load_outa", 64'(out_a), 64'h1234);
    check("load_outb", 64'(out_b), 64'h0);
    b_sel = 3'd0;
    #1;
    check("same_sel", 64'(out_b), 64'h1234);

    // Increment wrap on reg3
    i16 = 16'hFFFF; reg_sel = 8'hF7;
    tick();
    check("load_carry0", 64'(carry), 64'h0);
    fun = 3'b001;
    tick();
    read_a(3'd3, 16'h0000, "inc_wrap");
    check("inc_carry", 64'(carry), 64'h1);
    fun = 3'b111;
    tick();
    check("hold_carry", 64'(carry), 64'h0);
    fun = 3'b000;
    tick();
    read_a(3'd3, 16'hFFFF, "dec_wrap");
    check("dec_carry", 64'(carry), 64'h1);
    read_a(3'd0, 16'h1234, "reg0_kept");
    fun = 3'b011;
    tick();
    read_a(3'd3, 16'h0000, "clear_op");
    check("clear_carry", 64'(carry), 64'h0);

    // Broadcast load then rotate
    reg_sel = 8'h00; fun = 3'b010; i16 = 16'h00A5;
    tick();
    for (int k = 0; k < 8; k++) read_a(3'(k), 16'h00A5, "bcast_load");
    fun = 3'b110;
    tick();
    for (int k = 0; k < 8; k++) read_a(3'(k), 16'h014A, "bcast_rol");
    reg_sel = 8'hFB; fun = 3'b100;
    tick();
    read_a(3'd2, 16'h0294, "shl");
    read_a(3'd0, 16'h014A, "shl_hold");
    reg_sel = 8'hDF; fun = 3'b101;
    tick();
    read_a(3'd5, 16'h00A5, "shr");
    reg_sel = 8'hFD; fun = 3'b010; i16 = 16'h8001;
    tick();
    fun = 3'b110;
    tick();
    read_a(3'd1, 16'h0003, "rol_msb");

    // Clear sweep with a load attempted on the request edge
    reg_sel = 8'h00; fun = 3'b010; i16 = 16'h5555;
    tick();
    i16 = 16'hAAAA; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sweep_busy0", 64'(busy), 64'h1);
    read_a(3'd0, 16'h5555, "sweep_noload");
    for (int e = 1; e <= 8; e++) begin
      tick();
      read_a(3'(e - 1), 16'h0000, "sweep_clr");
      if (e < 8) read_a(3'(e), 16'h5555, "sweep_pending");
      check("sweep_busy", 64'(busy), (e < 8) ? 64'h1 : 64'h0);
      check("sweep_carry", 64'(carry), 64'h0);
    end
    fun = 3'b111;

    // ClearAll held across the return restarts immediately
    clr = 1'b1;
    tick();
    for (int e = 1; e <= 8; e++) tick();
    check("held_idle", 64'(busy), 64'h0);
    tick();
    check("held_restart", 64'(busy), 64'h1);
    clr = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    check("held_done", 64'(busy), 64'h0);

    // Reset mid-sweep at index 3
    reg_sel = 8'h00; fun = 3'b010; i16 = 16'h5555;
    tick();
    fun = 3'b111; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    read_a(3'd7, 16'h5555, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    for (int k = 0; k < 8; k++) read_a(3'(k), 16'h0000, "rst_clear");
    #2 rst_n = 1'b1;
    reg_sel = 8'h7F; fun = 3'b010; i16 = 16'h0F0F; a_sel = 3'd7; b_sel = 3'd6;
    tick();
    check("post_rst_a", 64'(out_a), 64'h0F0F);
    check("post_rst_b", 64'(out_b), 64'h0000);
    check("post_rst_busy", 64'(busy), 64'h0);
    fun = 3'b111;

    // Narrow instance
    reg_sel8 = 4'hE; fun8 = 3'b000; a_sel8 = 2'd0; b_sel8 = 2'd1;
    tick();
    check("w8_dec", 64'(out_a8), 64'hFF);
    check("w8_carry", 64'(carry8), 64'h1);
    check("w8_other", 64'(out_b8), 64'h00);
    fun8 = 3'b010; i8 = 8'h81;
    tick();
    check("w8_carry_clr", 64'(carry8), 64'h0);
    fun8 = 3'b101;
    tick();
    check("w8_shr", 64'(out_a8), 64'h40);
    reg_sel8 = 4'hF; clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      check("w8_busy", 64'(busy8), 64'h1);
      tick();
    end
    check("w8_busy_end", 64'(busy8), 64'h0);
    check("w8_swept", 64'(out_a8), 64'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
